// File: rtl/cic_pkg.sv
// cic_pkg: stage modes, width helpers and the legal differential-delay set for the CIC decimator
package cic_pkg;
  typedef enum logic {INTEGRATOR, COMB} stage_mode_e;
  localparam logic [3:0] D_LEGAL = 4'b0110;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cic_width(input int xw, input int n, input int rmax, input int d);
    return xw + n * (rmax + clog2(d));
  endfunction
endpackage

// File: rtl/cic_stage_ce.sv
// cic_stage_ce: one registered CIC integrator or comb stage, advanced only by valid inputs
module cic_stage_ce
  import cic_pkg::*;
#(
  parameter stage_mode_e MODE = INTEGRATOR,
  parameter int D = 1,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in,
  output logic         out_valid,
  output logic [W-1:0] out
);
  logic [W-1:0] out_q, out_d;
  logic valid_q;
  if (D > 3 || !D_LEGAL[D[1:0]]) begin : g_bad_d
    $error("cic_stage_ce: D must be 1 or 2");
  end
  if (MODE == COMB) begin : g_comb
    logic [D-1:0][W-1:0] dly_q, dly_d;
    always_comb begin
      dly_d = clr ? '0 : in_valid ? (D*W)'({dly_q, in}) : dly_q;
      out_d = clr ? '0 : in_valid ? in - dly_q[D-1] : out_q;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dly_q <= '0;
      else dly_q <= dly_d;
  end else begin : g_int
    always_comb out_d = clr ? '0 : in_valid ? out_q + in : out_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= in_valid & ~clr;
    end
  assign out       = out_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/cic_decimator_pipe.sv
// cic_decimator_pipe: N-stage CIC decimator, runtime power-of-two ratio, unity DC gain, valid-strobed
module cic_decimator_pipe
  import cic_pkg::*;
#(
  parameter int X_WIDTH        = 12,
  parameter int Y_WIDTH        = 12,
  parameter int N              = 3,
  parameter int D              = 1,
  parameter int RATIO_LOG2_MAX = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enabled,
  input  logic [clog2(RATIO_LOG2_MAX+1)-1:0]     ratio_log2,
  input  logic                                   x_valid,
  input  logic signed [X_WIDTH-1:0]              x,
  output logic                                   y_valid,
  output logic signed [Y_WIDTH-1:0]              y
);
  localparam int W  = cic_width(X_WIDTH, N, RATIO_LOG2_MAX, D);
  localparam int RW = clog2(RATIO_LOG2_MAX + 1);
  localparam int LD = clog2(D);
  localparam int CW = RATIO_LOG2_MAX;
  logic [RW-1:0] ratio_q, ratio_d;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic [N-1:0] tag_q, tag_d;
  logic [N:0][W-1:0] ig, cb;
  logic [N:0] ig_v, cb_v;
  logic acc, wrap, clr, yv_q, yv_d;
  logic [Y_WIDTH-1:0] y_sel, y_q, y_d;
  assign ig[0]   = {{(W-X_WIDTH){x[X_WIDTH-1]}}, x};
  assign ig_v[0] = acc;
  assign cb[0]   = ig[N];
  assign cb_v[0] = ig_v[N] & tag_q[N-1];
  // the tag rides alongside the integrator valids so combs see only the wrapping sample
  always_comb begin
    clr     = ~enabled;
    acc     = enabled & x_valid;
    last    = ~({CW{1'b1}} << ratio_q);
    wrap    = cnt_q == last;
    cnt_d   = clr ? '0 : acc ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    tag_d   = clr ? '0 : N'({tag_q, acc & wrap});
    ratio_d = clr ? (ratio_log2 > RW'(RATIO_LOG2_MAX) ? RW'(RATIO_LOG2_MAX) : ratio_log2) : ratio_q;
    y_sel   = '0;
    for (int r = 0; r <= RATIO_LOG2_MAX; r++)
      if (ratio_q == RW'(r)) y_sel = Y_WIDTH'(cb[N] >> (X_WIDTH - Y_WIDTH + N*(r + LD)));
    yv_d    = enabled & cb_v[N];
    y_d     = clr ? '0 : cb_v[N] ? y_sel : y_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  for (genvar i = 0; i < N; i++) begin : g_st
    cic_stage_ce #(.MODE(INTEGRATOR), .D(D), .W(W)) u_int (
      .clk, .rst_n, .clr,
      .in_valid(ig_v[i]), .in(ig[i]), .out_valid(ig_v[i+1]), .out(ig[i+1])
    );
    cic_stage_ce #(.MODE(COMB), .D(D), .W(W)) u_comb (
      .clk, .rst_n, .clr,
      .in_valid(cb_v[i]), .in(cb[i]), .out_valid(cb_v[i+1]), .out(cb[i+1])
    );
  end
  assign y       = y_q;
  assign y_valid = yv_q;
endmodule

// File: tb/tb_cic_decimator_pipe.sv
// tb_cic_decimator_pipe: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_cic_decimator_pipe;
  localparam int N = 3;
  logic clk = 0, rst_n = 0, enabled = 0, x_valid = 0;
  logic [2:0] ratio_log2 = '0;
  logic signed [11:0] x = '0;
  logic y_valid;
  logic signed [11:0] y;
  typedef struct {int cyc; int val; bit chk;} exp_t;
  exp_t sb[$];
  int exp_vals[$];
  int errors = 0, checks = 0, edge_n = 0, yv_cnt = 0;
  int acc_cnt = 0, cur_r = 0, n_skip = 0, dc_val = 0;

  cic_decimator_pipe #(.X_WIDTH(12), .Y_WIDTH(12), .N(N), .D(1), .RATIO_LOG2_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .ratio_log2(ratio_log2),
    .x_valid(x_valid), .x(x), .y_valid(y_valid), .y(y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && y_valid) begin
      yv_cnt++;
      if (sb.size() == 0) check("unexpected_y_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("latency", edge_n, e.cyc);
        if (e.chk) check("y_value", int'(y), e.val);
      end
    end
    if (sb.size() > 0 && sb[0].cyc < edge_n) begin
      check("missing_y_valid", edge_n, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic push(input int cyc);
    exp_t e;
    e.cyc = cyc;
    e.val = 0;
    e.chk = 1;
    if (n_skip > 0) begin
      e.chk = 0;
      n_skip--;
    end else if (exp_vals.size() > 0) e.val = exp_vals.pop_front();
    else e.val = dc_val;
    sb.push_back(e);
  endtask

  task automatic drive(input bit v, input int xv, input bit want = 1);
    @(negedge clk);
    x_valid = v;
    x = 12'(xv);
    if (v && enabled) begin
      if (acc_cnt == (1 << cur_r) - 1) begin
        acc_cnt = 0;
        if (want) push(edge_n + 2*N + 1);
      end else acc_cnt++;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) drive(0, 0);
  endtask

  task automatic start(input int r_in, input int r_model, input int skip, input int dc);
    @(negedge clk);
    enabled = 0;
    x_valid = 0;
    ratio_log2 = 3'(r_in);
    @(negedge clk);
    enabled = 1;
    acc_cnt = 0;
    cur_r = r_model;
    n_skip = skip;
    dc_val = dc;
    exp_vals.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int imp0[8] = '{800, 0, 0, 0, 0, 0, 0, 0};
    int imp1[6] = '{0, 800, 0, 0, 0, 0};
    int byp[6]  = '{0, 800, 0, -1000, 0, 0};
    int base;
    #12;
    check("reset_y", int'(y), 0);
    check("reset_y_valid", int'(y_valid), 0);
    @(negedge clk);
    rst_n = 1;
    // DC step at R=4
    start(2, 2, 3, 100);
    repeat (40) drive(1, 100);
    drain(12);
    // negative full scale at R=16
    start(4, 4, 3, -2048);
    repeat (128) drive(1, -2048);
    drain(12);
    // out-of-range ratio clamps to R=16
    start(7, 4, 3, 100);
    repeat (96) drive(1, 100);
    drain(12);
    // bypass: output mirrors input
    start(0, 0, 0, 0);
    foreach (byp[i]) exp_vals.push_back(byp[i]);
    foreach (byp[i]) drive(1, byp[i]);
    drain(12);
    // R=2 impulse, even phase: 3,1 taps of 1,3,3,1 over 8
    start(1, 1, 0, 0);
    exp_vals = {300, 100, 0, 0};
    foreach (imp0[i]) drive(1, imp0[i]);
    drain(12);
    // R=2 impulse, odd phase: 1,3 taps
    start(1, 1, 0, 0);
    exp_vals = {100, 300, 0};
    foreach (imp1[i]) drive(1, imp1[i]);
    drain(12);
    // ratio change while enabled is ignored, taken on re-enable
    start(2, 2, 3, 100);
    repeat (20) drive(1, 100);
    ratio_log2 = 3'd3;
    repeat (20) drive(1, 100);
    drain(12);
    start(3, 3, 3, 100);
    repeat (64) drive(1, 100);
    drain(12);
    // x_valid gaps
    start(2, 2, 3, 50);
    repeat (40) begin
      drive(1, 50);
      drive(0, 50);
    end
    drain(12);
    // enable falling with a tag in flight drops it
    start(2, 2, 3, 100);
    repeat (3) drive(1, 100);
    drive(1, 100, 0);
    base = yv_cnt;
    drain(2);
    @(negedge clk);
    enabled = 0;
    x_valid = 0;
    repeat (10) @(negedge clk);
    check("flush_discard", yv_cnt - base, 0);
    // async reset mid-stream
    start(2, 2, 3, 100);
    repeat (41) drive(1, 100);
    @(negedge clk);
    #2 rst_n = 0;
    enabled = 0;
    x_valid = 0;
    #1;
    check("async_rst_y", int'(y), 0);
    check("async_rst_y_valid", int'(y_valid), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    start(2, 2, 3, 100);
    repeat (40) drive(1, 100);
    drain(12);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
